// File: rtl/tsu0_core.sv
// tsu0 accumulator CPU core: fetch/exec sequencer over async ROM and handshaked RAM.
// Optional stack bounds checking is enabled by defining TSU0_STACK_CHECK_EN.
module tsu0_core #(
    parameter int ADDR_SIZE   = 12,
    parameter int WORD_SIZE   = 16,
    parameter int OPCODE_SIZE = 4,
    parameter int STACK_BASE  = 191,
    parameter int STACK_LIMIT = 254
) (
    input  logic                 sysclk,
    input  logic                 rst,
    output logic [ADDR_SIZE-1:0] rom_addr,
    input  logic [WORD_SIZE-1:0] rom_data,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_in,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_out,
    input  logic                 mem_ready,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_code
);

    if (WORD_SIZE - OPCODE_SIZE != ADDR_SIZE) begin : g_size_err
        $error("tsu0_core: WORD_SIZE-OPCODE_SIZE must equal ADDR_SIZE");
    end
    if (STACK_LIMIT < STACK_BASE) begin : g_stack_err
        $error("tsu0_core: STACK_LIMIT below STACK_BASE");
    end

    typedef enum logic [1:0] {FETCH, EXEC, HALT, FAULT} state_t;

    localparam logic [OPCODE_SIZE-1:0] OP_LD   = OPCODE_SIZE'(0);
    localparam logic [OPCODE_SIZE-1:0] OP_ST   = OPCODE_SIZE'(1);
    localparam logic [OPCODE_SIZE-1:0] OP_ADD  = OPCODE_SIZE'(2);
    localparam logic [OPCODE_SIZE-1:0] OP_SUB  = OPCODE_SIZE'(3);
    localparam logic [OPCODE_SIZE-1:0] OP_JMP  = OPCODE_SIZE'(4);
    localparam logic [OPCODE_SIZE-1:0] OP_BPL  = OPCODE_SIZE'(5);
    localparam logic [OPCODE_SIZE-1:0] OP_BNZ  = OPCODE_SIZE'(6);
    localparam logic [OPCODE_SIZE-1:0] OP_HLT  = OPCODE_SIZE'(7);
    localparam logic [OPCODE_SIZE-1:0] OP_PUSH = OPCODE_SIZE'(8);
    localparam logic [OPCODE_SIZE-1:0] OP_POP  = OPCODE_SIZE'(9);
    localparam logic [OPCODE_SIZE-1:0] OP_AND  = OPCODE_SIZE'(10);
    localparam logic [OPCODE_SIZE-1:0] OP_OR   = OPCODE_SIZE'(11);
    localparam logic [ADDR_SIZE-1:0]   SP_RST  = ADDR_SIZE'(STACK_BASE);
    localparam logic [ADDR_SIZE-1:0]   A_ONE   = ADDR_SIZE'(1);

    state_t               r_state, w_state_n;
    logic [ADDR_SIZE-1:0] r_ip, w_ip_n;
    logic [ADDR_SIZE-1:0] r_sp, w_sp_n;
    logic [WORD_SIZE-1:0] r_acc, w_acc_n;
    logic [WORD_SIZE-1:0] r_ir, w_ir_n;
    logic [ADDR_SIZE-1:0] r_mem_addr, w_mem_addr_n;
    logic [WORD_SIZE-1:0] r_mem_in, w_mem_in_n;
    logic                 r_mem_write, w_mem_write_n;
    logic                 r_halted, w_halted_n;
    logic                 r_fault, w_fault_n;
    logic [1:0]           r_fault_code, w_fault_code_n;

    logic [OPCODE_SIZE-1:0] w_op;
    logic [OPCODE_SIZE-1:0] w_fop;
    logic [ADDR_SIZE-1:0]   w_s;
    logic                   w_full;
    logic                   w_empty;

    assign w_op  = r_ir[WORD_SIZE-1 -: OPCODE_SIZE];
    assign w_fop = rom_data[WORD_SIZE-1 -: OPCODE_SIZE];
    assign w_s   = r_ir[ADDR_SIZE-1:0];

`ifdef TSU0_STACK_CHECK_EN
    localparam logic [ADDR_SIZE-1:0] SP_FULL = ADDR_SIZE'(STACK_LIMIT + 1);
    assign w_full  = (r_sp == SP_FULL);
    assign w_empty = (r_sp == SP_RST);
`else
    assign w_full  = 1'b0;
    assign w_empty = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_ip         <= '0;
            r_sp         <= SP_RST;
            r_acc        <= '0;
            r_ir         <= '0;
            r_mem_addr   <= '0;
            r_mem_in     <= '0;
            r_mem_write  <= 1'b0;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'd0;
        end else begin
            r_state      <= w_state_n;
            r_ip         <= w_ip_n;
            r_sp         <= w_sp_n;
            r_acc        <= w_acc_n;
            r_ir         <= w_ir_n;
            r_mem_addr   <= w_mem_addr_n;
            r_mem_in     <= w_mem_in_n;
            r_mem_write  <= w_mem_write_n;
            r_halted     <= w_halted_n;
            r_fault      <= w_fault_n;
            r_fault_code <= w_fault_code_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_ip_n         = r_ip;
        w_sp_n         = r_sp;
        w_acc_n        = r_acc;
        w_ir_n         = r_ir;
        w_mem_addr_n   = r_mem_addr;
        w_mem_in_n     = r_mem_in;
        w_mem_write_n  = r_mem_write;
        w_halted_n     = r_halted;
        w_fault_n      = r_fault;
        w_fault_code_n = r_fault_code;
        case (r_state)
            FETCH: begin
                // Write ops launch their strobe here so it is live on EXEC entry.
                w_ir_n        = rom_data;
                w_ip_n        = r_ip + A_ONE;
                w_mem_addr_n  = rom_data[ADDR_SIZE-1:0];
                w_mem_write_n = 1'b0;
                w_state_n     = EXEC;
                if (w_fop == OP_POP) begin
                    w_mem_addr_n = r_sp - A_ONE;
                end else if (w_fop == OP_ST) begin
                    w_mem_in_n    = r_acc;
                    w_mem_write_n = 1'b1;
                end else if (w_fop == OP_PUSH) begin
                    w_mem_addr_n  = r_sp;
                    w_mem_in_n    = r_acc;
                    w_mem_write_n = !w_full;
                end
            end
            EXEC: begin
                case (w_op)
                    OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        if (mem_ready) begin
                            w_state_n = FETCH;
                            case (w_op)
                                OP_ADD:  w_acc_n = r_acc + mem_out;
                                OP_SUB:  w_acc_n = r_acc - mem_out;
                                OP_AND:  w_acc_n = r_acc & mem_out;
                                OP_OR:   w_acc_n = r_acc | mem_out;
                                default: w_acc_n = mem_out;
                            endcase
                        end
                    end
                    OP_POP: begin
                        if (w_empty) begin
                            w_fault_n      = 1'b1;
                            w_fault_code_n = 2'd3;
                            w_state_n      = FAULT;
                        end else if (mem_ready) begin
                            w_acc_n   = mem_out;
                            w_sp_n    = r_sp - A_ONE;
                            w_state_n = FETCH;
                        end
                    end
                    OP_ST: begin
                        if (mem_ready) begin
                            w_mem_write_n = 1'b0;
                            w_state_n     = FETCH;
                        end
                    end
                    OP_PUSH: begin
                        if (w_full) begin
                            w_fault_n      = 1'b1;
                            w_fault_code_n = 2'd2;
                            w_state_n      = FAULT;
                        end else if (mem_ready) begin
                            w_mem_write_n = 1'b0;
                            w_sp_n        = r_sp + A_ONE;
                            w_state_n     = FETCH;
                        end
                    end
                    OP_JMP: begin
                        w_ip_n    = w_s;
                        w_state_n = FETCH;
                    end
                    OP_BPL: begin
                        if (!r_acc[WORD_SIZE-1]) w_ip_n = w_s;
                        w_state_n = FETCH;
                    end
                    OP_BNZ: begin
                        if (r_acc != '0) w_ip_n = w_s;
                        w_state_n = FETCH;
                    end
                    OP_HLT: begin
                        w_halted_n = 1'b1;
                        w_state_n  = HALT;
                    end
                    default: begin
                        w_fault_n      = 1'b1;
                        w_fault_code_n = 2'd1;
                        w_state_n      = FAULT;
                    end
                endcase
            end
            HALT, FAULT: begin
                w_mem_write_n = 1'b0;
            end
            default: w_state_n = FETCH;
        endcase
    end

    assign rom_addr   = r_ip;
    assign mem_addr   = r_mem_addr;
    assign mem_in     = r_mem_in;
    assign mem_write  = r_mem_write;
    assign halted     = r_halted;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule

// File: tb/tb_tsu0_core.sv
// Self-checking bench for tsu0_core: table-driven ALU programs plus
// directed stall, branch, stack, fault and reset sequences.
module tb_tsu0_core;

    logic        sysclk;
    logic        rst;
    logic [11:0] rom_addr;
    logic [15:0] rom_data;
    logic [11:0] mem_addr;
    logic [15:0] mem_in;
    logic        mem_write;
    logic [15:0] mem_out;
    logic        mem_ready;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;

    logic [15:0] rom [4096];
    logic [15:0] ram [4096];
    int          wr_cnt;
    int          n_chk;
    int          n_err;

    tsu0_core dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .mem_addr   (mem_addr),
        .mem_in     (mem_in),
        .mem_write  (mem_write),
        .mem_out    (mem_out),
        .mem_ready  (mem_ready),
        .halted     (halted),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    assign rom_data = rom[rom_addr];
    assign mem_out  = ram[mem_addr];

    always @(posedge sysclk) begin
        if (mem_write && mem_ready) begin
            ram[mem_addr] = mem_in;
            wr_cnt = wr_cnt + 1;
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 16'h7000;
            ram[i] = 16'h0000;
        end
        wr_cnt = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_done(input string name, input int max);
        int c;
        c = 0;
        while (!(halted || fault) && c < max) begin
            tick();
            c++;
        end
        if (!(halted || fault)) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: timeout after %0d cycles, required halt/fault", name, max);
        end
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        mem_ready = 1'b1;
        clear_mem();

        vecs[0] = '{4'h2, 16'h0005, 16'h0007, 16'h000C};
        vecs[1] = '{4'h2, 16'hFFFF, 16'h0002, 16'h0001};
        vecs[2] = '{4'h3, 16'h0007, 16'h0005, 16'h0002};
        vecs[3] = '{4'h3, 16'h0000, 16'h0001, 16'hFFFF};
        vecs[4] = '{4'hA, 16'hF0F0, 16'h3C3C, 16'h3030};
        vecs[5] = '{4'hB, 16'hF0F0, 16'h0F01, 16'hFFF1};
        vecs[6] = '{4'h0, 16'h1234, 16'hABCD, 16'hABCD};

        // Basic program with exact latency.
        clear_mem();
        rom[0] = 16'h0010; rom[1] = 16'h2011;
        rom[2] = 16'h1012; rom[3] = 16'h7000;
        ram[16] = 16'd5; ram[17] = 16'd7;
        rst = 1'b1;
        tick();
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fault", 32'({fault, fault_code}), 32'h0);
        do_reset();
        repeat (7) tick();
        chk("basic_not_halted_7", 32'(halted), 32'h0);
        tick();
        chk("basic_halted_8", 32'(halted), 32'h1);
        chk("basic_result", 32'(ram[18]), 32'd12);
        repeat (3) tick();
        chk("basic_mem_write_low", 32'(mem_write), 32'h0);
        chk("basic_ip_frozen", 32'(rom_addr), 32'h4);
        chk("basic_wr_cnt", 32'(wr_cnt), 32'd1);

        // Table of ALU programs.
        for (int i = 0; i < 7; i++) begin
            clear_mem();
            rom[0] = 16'h0010;
            rom[1] = {vecs[i].op, 12'h011};
            rom[2] = 16'h1012;
            rom[3] = 16'h7000;
            ram[16] = vecs[i].a;
            ram[17] = vecs[i].b;
            do_reset();
            run_done($sformatf("alu%0d", i), 40);
            chk($sformatf("alu%0d_result", i), 32'(ram[18]), 32'(vecs[i].exp));
            chk($sformatf("alu%0d_halted", i), 32'(halted), 32'h1);
        end

        // Read stall of 3 cycles on the first load.
        clear_mem();
        rom[0] = 16'h0010; rom[1] = 16'h2011;
        rom[2] = 16'h1012; rom[3] = 16'h7000;
        ram[16] = 16'd5; ram[17] = 16'd7;
        do_reset();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("stall_ip_c2", 32'(rom_addr), 32'h1);
        tick();
        tick();
        chk("stall_ip_c4", 32'(rom_addr), 32'h1);
        mem_ready = 1'b1;
        repeat (6) tick();
        chk("stall_not_halted_10", 32'(halted), 32'h0);
        tick();
        chk("stall_halted_11", 32'(halted), 32'h1);
        chk("stall_result", 32'(ram[18]), 32'd12);

        // Branches: BPL not taken on negative, BNZ taken on nonzero.
        clear_mem();
        rom[0] = 16'h0010; rom[1] = 16'h5020;
        rom[2] = 16'h0011; rom[3] = 16'h6020;
        rom[4] = 16'h7000; rom[32] = 16'h7000;
        ram[16] = 16'h8000; ram[17] = 16'h0001;
        do_reset();
        repeat (4) tick();
        chk("bpl_not_taken_ip", 32'(rom_addr), 32'h2);
        repeat (4) tick();
        chk("bnz_taken_ip", 32'(rom_addr), 32'h020);
        run_done("branch", 20);
        chk("branch_end_ip", 32'(rom_addr), 32'h021);

        // Stack LIFO order.
        clear_mem();
        rom[0] = 16'h0010; rom[1] = 16'h8000; rom[2] = 16'h0011;
        rom[3] = 16'h8000; rom[4] = 16'h9000; rom[5] = 16'h1012;
        rom[6] = 16'h9000; rom[7] = 16'h1013; rom[8] = 16'h7000;
        ram[16] = 16'd5; ram[17] = 16'd7;
        do_reset();
        run_done("lifo", 60);
        chk("lifo_first_pop", 32'(ram[18]), 32'd7);
        chk("lifo_second_pop", 32'(ram[19]), 32'd5);
        chk("lifo_slot191", 32'(ram[191]), 32'd5);

        // 65 pushes from an empty stack.
        clear_mem();
        rom[0] = 16'h0010;
        for (int i = 1; i <= 65; i++) rom[i] = 16'h8000;
        rom[66] = 16'h7000;
        ram[16] = 16'h55AA;
        ram[255] = 16'hDEAD;
        do_reset();
        run_done("push65", 400);
        chk("push_slot254", 32'(ram[254]), 32'h55AA);
`ifdef TSU0_STACK_CHECK_EN
        chk("push65_fault", 32'({fault, fault_code}), 32'h6);
        chk("push65_no_write", 32'(ram[255]), 32'hDEAD);
        chk("push65_wr_cnt", 32'(wr_cnt), 32'd64);
        chk("push65_ip", 32'(rom_addr), 32'd66);
`else
        chk("push65_fault", 32'({fault, fault_code}), 32'h0);
        chk("push65_wrote", 32'(ram[255]), 32'h55AA);
        chk("push65_wr_cnt", 32'(wr_cnt), 32'd65);
`endif

        // Pop from an empty stack.
        clear_mem();
        rom[0] = 16'h9000; rom[1] = 16'h1012; rom[2] = 16'h7000;
        ram[190] = 16'h1234;
        do_reset();
        run_done("pop_empty", 40);
`ifdef TSU0_STACK_CHECK_EN
        chk("pop_empty_fault", 32'({fault, fault_code}), 32'h7);
        chk("pop_empty_no_store", 32'(ram[18]), 32'h0);
`else
        chk("pop_empty_fault", 32'({fault, fault_code}), 32'h0);
        chk("pop_wrap_value", 32'(ram[18]), 32'h1234);
`endif

        // Illegal opcode freezes, then reset recovers.
        clear_mem();
        rom[0] = 16'h0010; rom[1] = 16'hC000; rom[2] = 16'h1012;
        ram[16] = 16'h0042;
        do_reset();
        run_done("illegal", 20);
        chk("illegal_fault", 32'({fault, fault_code}), 32'h5);
        chk("illegal_not_halted", 32'(halted), 32'h0);
        chk("illegal_ip", 32'(rom_addr), 32'h2);
        repeat (4) tick();
        chk("illegal_ip_frozen", 32'(rom_addr), 32'h2);
        chk("illegal_no_write", 32'({mem_write, 31'(wr_cnt)}), 32'h0);
        rst = 1'b1;
        tick();
        chk("rec_rom_addr", 32'(rom_addr), 32'h0);
        chk("rec_mem_addr", 32'(mem_addr), 32'h0);
        chk("rec_mem_in", 32'(mem_in), 32'h0);
        chk("rec_status", 32'({mem_write, halted, fault, fault_code}), 32'h0);
        rst = 1'b0;
        tick();
        chk("rec_fetch_resumes", 32'(rom_addr), 32'h1);

        // Reset during a stalled write.
        clear_mem();
        rom[0] = 16'h0010; rom[1] = 16'h1012;
        ram[16] = 16'h1111;
        do_reset();
        repeat (3) tick();
        chk("wr_strobe", 32'(mem_write), 32'h1);
        chk("wr_data", 32'(mem_in), 32'h1111);
        chk("wr_addr", 32'(mem_addr), 32'h012);
        mem_ready = 1'b0;
        tick();
        chk("wr_held", 32'(mem_write), 32'h1);
        rst = 1'b1;
        tick();
        chk("wr_dropped", 32'(mem_write), 32'h0);
        mem_ready = 1'b1;
        tick();
        chk("wr_none_observed", 32'(wr_cnt), 32'd0);
        chk("wr_ram_clean", 32'(ram[18]), 32'h0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
